// File: rtl/axis_sink_monitor.sv
// AXI-Stream sink with selectable backpressure and saturating beat/packet/stall statistics.
// Optional tdata sequence checker enabled by defining AXIS_SINK_MONITOR_SEQ_CHECK_EN.
module axis_sink_monitor #(
  parameter int TDATA_BITS   = 32,
  parameter int CNT_BITS     = 32,
  parameter int LED_BIT      = 24,
  parameter int READY_PERIOD = 4,
  parameter int READY_ON     = 3
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [TDATA_BITS-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [1:0]            mode,
  input  logic                  clr,
  output logic [CNT_BITS-1:0]   beat_count,
  output logic [CNT_BITS-1:0]   pkt_count,
  output logic [CNT_BITS-1:0]   stall_count,
  output logic                  in_pkt,
  output logic                  led_out
`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
  ,
  output logic [CNT_BITS-1:0]   seq_err_count
`endif
);

  localparam int PHASE_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(READY_PERIOD - 1);
  localparam logic [PHASE_W:0]   ON_LIMIT   = (PHASE_W + 1)'(READY_ON);
  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;

`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
  localparam int NCNT = 4;
`else
  localparam int NCNT = 3;
`endif

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_e;

  logic               tready_q, tready_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               lfsr_fb;
  logic               duty_ready;
  logic               beat_acc;
  pkt_state_e         state_q;
  logic               in_pkt_q;
  logic               led_q;
  logic [NCNT-1:0]    cnt_inc;
  logic [CNT_BITS-1:0] cnt_val [NCNT];

  assign beat_acc = s_axis_tvalid & tready_q;

  // Backpressure sources: phase and LFSR free-run in every mode so that
  // switching modes never restarts the pattern.
  always_comb begin
    phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
    duty_ready = ({1'b0, phase_q} < ON_LIMIT);
    lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d     = {lfsr_fb, lfsr_q[15:1]};
    if (lfsr_d == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end
    tready_d = 1'b0;
    case (mode)
      2'b00:   tready_d = 1'b1;
      2'b01:   tready_d = duty_ready;
      2'b10:   tready_d = lfsr_q[0];
      default: tready_d = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tready_q <= 1'b0;
      phase_q  <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      tready_q <= tready_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Packet tracker; a tlast beat from IDLE is a complete single-beat packet.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      in_pkt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_acc && !s_axis_tlast) begin
            state_q  <= IN_PKT;
            in_pkt_q <= 1'b1;
          end
        end
        IN_PKT: begin
          if (beat_acc && s_axis_tlast) begin
            state_q  <= IDLE;
            in_pkt_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_pkt_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_inc[0] = beat_acc;
  assign cnt_inc[1] = beat_acc & s_axis_tlast;
  assign cnt_inc[2] = s_axis_tvalid & ~tready_q;

`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
  logic [TDATA_BITS-1:0] seq_exp_q;
  logic                  seq_armed_q;

  // The first beat after reset/clr only seeds the expectation.
  always_ff @(posedge aclk) begin
    if (!aresetn || clr) begin
      seq_armed_q <= 1'b0;
      seq_exp_q   <= '0;
    end else if (beat_acc) begin
      seq_armed_q <= 1'b1;
      seq_exp_q   <= s_axis_tdata + TDATA_BITS'(1);
    end
  end

  assign cnt_inc[3]    = beat_acc & seq_armed_q & (s_axis_tdata != seq_exp_q);
  assign seq_err_count = cnt_val[3];
`else
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
`endif

  // Saturating counters; clr wins over a same-cycle increment.
  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (cnt_inc[gi] && (cnt_q != {CNT_BITS{1'b1}})) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_val[gi] = cnt_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      led_q <= 1'b0;
    end else begin
      led_q <= cnt_val[0][LED_BIT];
    end
  end

  assign s_axis_tready = tready_q;
  assign beat_count    = cnt_val[0];
  assign pkt_count     = cnt_val[1];
  assign stall_count   = cnt_val[2];
  assign in_pkt        = in_pkt_q;
  assign led_out       = led_q;

endmodule

// File: tb/tb_axis_sink_monitor.sv
// Directed bench for axis_sink_monitor: a count-based model checked every cycle
// against a 32-bit-counter instance and an 8-bit-counter instance, plus literal expectations.
module tb_axis_sink_monitor;

  localparam int P  = 4;
  localparam int ON = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic [1:0]  mode;
  logic        clr;

  logic        a_tready, a_in_pkt, a_led;
  logic [31:0] a_beat, a_pkt, a_stall;
  logic        b_tready, b_in_pkt, b_led;
  logic [7:0]  b_beat, b_pkt, b_stall;
`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
  logic [31:0] a_seq;
  logic [7:0]  b_seq;
`endif

  always #5 aclk = ~aclk;

  axis_sink_monitor #(.TDATA_BITS(32), .CNT_BITS(32), .LED_BIT(24),
                      .READY_PERIOD(P), .READY_ON(ON)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(a_tready), .mode(mode), .clr(clr),
    .beat_count(a_beat), .pkt_count(a_pkt), .stall_count(a_stall),
    .in_pkt(a_in_pkt), .led_out(a_led)
`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
    , .seq_err_count(a_seq)
`endif
  );

  axis_sink_monitor #(.TDATA_BITS(32), .CNT_BITS(8), .LED_BIT(7),
                      .READY_PERIOD(P), .READY_ON(ON)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(b_tready), .mode(mode), .clr(clr),
    .beat_count(b_beat), .pkt_count(b_pkt), .stall_count(b_stall),
    .in_pkt(b_in_pkt), .led_out(b_led)
`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
    , .seq_err_count(b_seq)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic longint satv(input longint v, input int bits);
    longint mx;
    mx = (longint'(1) << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic bitof(input longint v, input int b);
    return v[b];
  endfunction

  // Model: true event counts since last clr/reset; DUT values are these clipped.
  longint      m_beat, m_pkt, m_stall;
  logic        m_tready, m_in_pkt, m_led32, m_led8;
  int          m_edge;
  logic [15:0] m_lfsr;
  logic        m_acc;

  assign m_acc = tvalid && m_tready;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_beat   <= 0;
      m_pkt    <= 0;
      m_stall  <= 0;
      m_tready <= 1'b0;
      m_in_pkt <= 1'b0;
      m_led32  <= 1'b0;
      m_led8   <= 1'b0;
      m_edge   <= 0;
      m_lfsr   <= 16'hACE1;
    end else begin
      case (mode)
        2'd0:    m_tready <= 1'b1;
        2'd1:    m_tready <= ((m_edge % P) < ON);
        2'd2:    m_tready <= m_lfsr[0];
        default: m_tready <= 1'b0;
      endcase
      m_edge  <= m_edge + 1;
      m_lfsr  <= lfsr_step(m_lfsr);
      m_beat  <= clr ? 0 : m_beat + (m_acc ? 1 : 0);
      m_pkt   <= clr ? 0 : m_pkt + ((m_acc && tlast) ? 1 : 0);
      m_stall <= clr ? 0 : m_stall + ((tvalid && !m_tready) ? 1 : 0);
      if (m_acc) m_in_pkt <= !tlast;
      m_led32 <= bitof(satv(m_beat, 32), 24);
      m_led8  <= bitof(satv(m_beat, 8), 7);
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("a_tready", a_tready, m_tready);
      chk("a_beat",   a_beat,   satv(m_beat, 32));
      chk("a_pkt",    a_pkt,    satv(m_pkt, 32));
      chk("a_stall",  a_stall,  satv(m_stall, 32));
      chk("a_in_pkt", a_in_pkt, m_in_pkt);
      chk("a_led",    a_led,    m_led32);
      chk("b_tready", b_tready, m_tready);
      chk("b_beat",   b_beat,   satv(m_beat, 8));
      chk("b_pkt",    b_pkt,    satv(m_pkt, 8));
      chk("b_stall",  b_stall,  satv(m_stall, 8));
      chk("b_in_pkt", b_in_pkt, m_in_pkt);
      chk("b_led",    b_led,    m_led8);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  logic [39:0] trv;

  initial begin
    aresetn = 1'b0;
    tdata   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    mode    = 2'd0;
    clr     = 1'b0;

    chk("lfsr_step_seed", lfsr_step(16'hACE1), 16'h5670);
    chk("lfsr_step_two",  lfsr_step(16'h5670), 16'hAB38);

    step(1);
    cmp_en = 1'b1;
    step(2);
    chk("rst_tready", a_tready, 0);
    chk("rst_beat",   a_beat,   0);
    chk("rst_in_pkt", a_in_pkt, 0);
    chk("rst_led",    b_led,    0);

    aresetn = 1'b1;
    step(1);
    chk("release_tready", a_tready, 1);

    // Two five-beat packets at full throughput.
    for (int i = 1; i <= 10; i++) begin
      tvalid = 1'b1;
      tlast  = (i == 5 || i == 10);
      tdata  = i;
      step(1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("p10_beat",   a_beat,   10);
    chk("p10_pkt",    a_pkt,    2);
    chk("p10_stall",  a_stall,  0);
    chk("p10_in_pkt", a_in_pkt, 0);
    chk("p10_model_beat", m_beat, 10);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_beat", a_beat, 0);

    // Duty-cycle backpressure over 40 valid cycles.
    mode = 2'd1;
    step(1);
    tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      trv[i] = a_tready;
      step(1);
    end
    tvalid = 1'b0;
    chk("duty_ones4", $countones(trv[3:0]), 3);
    chk("duty_periodic", (trv[39:4] == trv[35:0]) ? 1 : 0, 1);
    chk("duty_beat",   a_beat,   30);
    chk("duty_stall",  a_stall,  10);
    chk("duty_in_pkt", a_in_pkt, 1);

    mode = 2'd0;
    step(1);
    tvalid = 1'b1;
    tlast  = 1'b1;
    step(1);
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("close_pkt",    a_pkt,    1);
    chk("close_in_pkt", a_in_pkt, 0);
    chk("close_beat",   a_beat,   31);

    // Mode changes under continuous valid, including pseudo-random.
    tvalid = 1'b1;
    mode = 2'd2;
    for (int i = 0; i < 30; i++) begin tlast = (i % 3 == 0); step(1); end
    mode = 2'd1;
    for (int i = 0; i < 7; i++)  begin tlast = (i % 3 == 0); step(1); end
    mode = 2'd3;
    step(5);
    mode = 2'd0;
    for (int i = 0; i < 3; i++)  begin tlast = (i % 3 == 0); step(1); end
    mode = 2'd2;
    for (int i = 0; i < 10; i++) begin tlast = (i % 3 == 0); step(1); end
    tvalid = 1'b0;
    tlast  = 1'b0;

    // Constant stall, then clr colliding with an accepted beat.
    mode = 2'd3;
    clr  = 1'b1;
    step(1);
    clr    = 1'b0;
    tvalid = 1'b1;
    step(8);
    tvalid = 1'b0;
    chk("stall8_stall", a_stall, 8);
    chk("stall8_beat",  a_beat,  0);
    mode = 2'd0;
    step(1);
    tvalid = 1'b1;
    tlast  = 1'b1;
    clr    = 1'b1;
    step(1);
    clr    = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("clrpri_beat",   a_beat,   0);
    chk("clrpri_pkt",    a_pkt,    0);
    chk("clrpri_stall",  a_stall,  0);
    chk("clrpri_in_pkt", a_in_pkt, 0);

    // Reset in the middle of a packet.
    tvalid = 1'b1;
    step(3);
    tvalid = 1'b0;
    chk("mid_in_pkt", a_in_pkt, 1);
    chk("mid_beat",   a_beat,   3);
    aresetn = 1'b0;
    step(2);
    chk("midrst_in_pkt", a_in_pkt, 0);
    chk("midrst_tready", a_tready, 0);
    aresetn = 1'b1;
    step(1);
    tvalid = 1'b1;
    tlast  = 1'b1;
    step(1);
    tvalid = 1'b0;
    tlast  = 1'b0;
    chk("after_rst_pkt",    a_pkt,    1);
    chk("after_rst_in_pkt", a_in_pkt, 0);
    chk("after_rst_beat",   a_beat,   1);

    // 300 beats saturate the 8-bit instance.
    tvalid = 1'b1;
    step(300);
    tvalid = 1'b0;
    chk("sat_b_beat", b_beat, 255);
    chk("sat_a_beat", a_beat, 301);
    chk("sat_b_led",  b_led,  1);
    step(1);
    chk("sat_b_led_hold", b_led, 1);

`ifdef AXIS_SINK_MONITOR_SEQ_CHECK_EN
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    foreach (trv[i]) begin
      if (i < 6) begin
        tvalid = 1'b1;
        case (i)
          0: tdata = 0;
          1: tdata = 1;
          2: tdata = 2;
          3: tdata = 7;
          4: tdata = 8;
          default: tdata = 9;
        endcase
        step(1);
      end
    end
    tvalid = 1'b0;
    chk("seq_a_err", a_seq, 1);
    chk("seq_b_err", b_seq, 1);
`endif

    step(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
